// File: rtl/upc_scan_tx.sv
// Serial transmitter for 4-bit item records {Mark,U,P,C}: start, 4 data bits LSB-first, stop.
// Define UPC_SCAN_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module upc_scan_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rec_in,
    input  logic       rec_valid,
    output logic       rec_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UPC_SCAN_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] clk_cnt, clk_cnt_d;
    logic [1:0]    bit_cnt, bit_cnt_d;
    logic [3:0]    shreg, shreg_d;
    logic          tx_q, tx_d;
    logic          bit_end;
`ifdef UPC_SCAN_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign bit_end   = (clk_cnt == LAST_CLK);
    assign rec_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == STOP) && bit_end;
    assign tx_out    = tx_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        tx_d      = tx_q;
`ifdef UPC_SCAN_TX_PARITY_EN
        par_d     = par_q;
`endif
        // tx_d is the line level for the cycle after this edge, so tx_out stays a clean register.
        case (state)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                if (rec_valid) begin
                    state_d = START;
                    shreg_d = rec_in;
                    tx_d    = 1'b0;
`ifdef UPC_SCAN_TX_PARITY_EN
                    par_d   = ^rec_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = shreg[0];
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shreg_d   = {1'b0, shreg[3:1]};
                    if (bit_cnt == 2'd3) begin
                        bit_cnt_d = '0;
`ifdef UPC_SCAN_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = par_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 2'd1;
                        tx_d      = shreg[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
`ifdef UPC_SCAN_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
`ifdef UPC_SCAN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            tx_q    <= tx_d;
`ifdef UPC_SCAN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
